// File: rtl/instr_prefetch_queue_if.sv
// Fetch-side bundle between the prefetch queue, instruction memory and controller.
// Perf counter signals exist only when FETCH_PERF_CNT_EN is defined.
interface instr_prefetch_queue_if #(
    parameter int PC_W  = 10,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            fetch_en;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [PC_W-1:0] out_pc;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic [PC_W-1:0] fetch_pc;
    logic [CW-1:0]   count;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]     perf_fetched;
    logic [15:0]     perf_flushed;
    logic [15:0]     perf_stall;

    modport slave (
        input  fetch_en, imem_rdata, out_ready, redirect_valid, redirect_pc,
        output imem_req, imem_addr, out_valid, out_instr, out_pc, fetch_pc, count,
        output perf_fetched, perf_flushed, perf_stall
    );
    modport master (
        output fetch_en, imem_rdata, out_ready, redirect_valid, redirect_pc,
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, fetch_pc, count,
        input  perf_fetched, perf_flushed, perf_stall
    );
`else
    modport slave (
        input  fetch_en, imem_rdata, out_ready, redirect_valid, redirect_pc,
        output imem_req, imem_addr, out_valid, out_instr, out_pc, fetch_pc, count
    );
    modport master (
        output fetch_en, imem_rdata, out_ready, redirect_valid, redirect_pc,
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, fetch_pc, count
    );
`endif
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: owns the PC, issues 1-cycle-latency imem reads and buffers
// {instr, pc} in a small FIFO. Define FETCH_PERF_CNT_EN to add saturating perf counters.
module instr_prefetch_queue #(
    parameter int          PC_W     = 10,
    parameter int          DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_prefetch_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;
    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
    } entry_t;

    state_e          state_q, state_d;
    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            inflight_q;
    logic [PC_W-1:0] tag_q;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW:0]     occ;
    logic            req, push, pop;

    // Credit counts the outstanding response so the FIFO can never overflow.
    assign occ  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign req  = (state_q == RUN) && !bus.redirect_valid && (occ < (CW+1)'(DEPTH));
    assign push = inflight_q && !bus.redirect_valid;
    assign pop  = (count_q != '0) && bus.out_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.fetch_en ? RUN : PAUSE;
            RUN:     if (!bus.fetch_en) state_d = PAUSE;
            PAUSE:   if (bus.fetch_en) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect_valid) fetch_pc_d = bus.redirect_pc;
        else if (req)           fetch_pc_d = fetch_pc_q + PC_W'(1);
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= PC_W'(RESET_PC);
            count_q    <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= req;
            if (req) tag_q <= fetch_pc_q;
            // The same-cycle pop is honoured, but a flush empties the queue anyway.
            if (bus.redirect_valid) begin
                count_q  <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                count_q <= count_d;
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) mem_q[wr_ptr_q] <= '{instr: bus.imem_rdata, pc: tag_q};
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.fetch_pc  = fetch_pc_q;
    assign bus.count     = count_q;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_instr = mem_q[rd_ptr_q].instr;
    assign bus.out_pc    = mem_q[rd_ptr_q].pc;

    no_overflow_a : assert property (@(posedge clk) disable iff (reset)
        !(push && (count_q == CW'(DEPTH))));

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetched_q, flushed_q, stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q <= '0;
            flushed_q <= '0;
            stall_q   <= '0;
        end else begin
            if (push && (fetched_q != 16'hFFFF)) fetched_q <= fetched_q + 16'd1;
            if (bus.redirect_valid && (flushed_q != 16'hFFFF)) flushed_q <= flushed_q + 16'd1;
            if ((state_q == RUN) && !req && !bus.redirect_valid && (stall_q != 16'hFFFF))
                stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.perf_fetched = fetched_q;
    assign bus.perf_flushed = flushed_q;
    assign bus.perf_stall   = stall_q;
`endif
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: directed scenarios then random traffic, every cycle
// compared against a queue-based model of the fetch stream.
module tb_instr_prefetch_queue;
    localparam int PC_W  = 10;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fen = 1'b1, rdy = 1'b1, redir = 1'b0;
    logic [PC_W-1:0] rpc = '0;

    int n_checks = 0;
    int n_pass   = 0;

    instr_prefetch_queue_if #(.PC_W(PC_W), .DEPTH(DEPTH)) bus ();

    instr_prefetch_queue #(.PC_W(PC_W), .DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    assign bus.fetch_en       = fen;
    assign bus.out_ready      = rdy;
    assign bus.redirect_valid = redir;
    assign bus.redirect_pc    = rpc;

    always #5 clk = ~clk;

    // Instruction memory: word at address a is {22'h0, a}; junk when not requested.
    always @(posedge clk)
        bus.imem_rdata <= bus.imem_req ? {22'h0, bus.imem_addr} : 32'($urandom);

    // Model: queue of PCs awaiting pop, one pending response, fetch PC, run flag.
    logic [PC_W-1:0] mq [$];
    logic [PC_W-1:0] obs [$];
    logic            m_pend    = 1'b0;
    logic [PC_W-1:0] m_pend_pc = '0;
    logic [PC_W-1:0] m_pc      = '0;
    logic            m_run     = 1'b0;
    logic            exp_req   = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    int m_fetched = 0, m_flushed = 0, m_stall = 0;
`endif

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_checks = n_checks + 1;
        assert (o === e) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, o, e);
    endtask

    task automatic cycle();
        @(negedge clk);
        exp_req = m_run && !redir && ((mq.size() + int'(m_pend)) < DEPTH);
        if (!rst) begin
            chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
            if (exp_req) chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
            chk("fetch_pc", 32'(bus.fetch_pc), 32'(m_pc));
            chk("count", 32'(bus.count), 32'(mq.size()));
            chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("out_pc", 32'(bus.out_pc), 32'(mq[0]));
                chk("out_instr", bus.out_instr, {22'h0, mq[0]});
                if (rdy) obs.push_back(bus.out_pc);
            end
`ifdef FETCH_PERF_CNT_EN
            chk("perf_fetched", 32'(bus.perf_fetched), 32'(m_fetched));
            chk("perf_flushed", 32'(bus.perf_flushed), 32'(m_flushed));
            chk("perf_stall", 32'(bus.perf_stall), 32'(m_stall));
`endif
        end
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_pend = 1'b0;
            m_pc   = '0;
            m_run  = 1'b0;
`ifdef FETCH_PERF_CNT_EN
            m_fetched = 0; m_flushed = 0; m_stall = 0;
`endif
        end else begin
`ifdef FETCH_PERF_CNT_EN
            if (m_pend && !redir && m_fetched < 65535) m_fetched++;
            if (redir && m_flushed < 65535) m_flushed++;
            if (m_run && !exp_req && !redir && m_stall < 65535) m_stall++;
`endif
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (redir) begin
                mq.delete();
                m_pend = 1'b0;
                m_pc   = rpc;
            end else begin
                if (m_pend) mq.push_back(m_pend_pc);
                m_pend    = exp_req;
                m_pend_pc = m_pc;
                if (exp_req) m_pc = m_pc + 1'b1;
            end
            m_run = fen;
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        bit hit;
        // Reset, then check the post-reset state directly.
        rst = 1'b1; fen = 1'b1; rdy = 1'b1;
        run(2);
        rst = 1'b0;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_fetch_pc", 32'(bus.fetch_pc), 32'd0);
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        obs.delete();
        run(10);
        chk("stream_first_pc", 32'(obs.size() > 0 ? obs[0] : 10'h3FF), 32'd0);
        chk("stream_third_pc", 32'(obs.size() > 2 ? obs[2] : 10'h3FF), 32'd2);

        // Back-pressure: queue fills to DEPTH and requests stop.
        redir = 1'b1; rpc = '0; run(1); redir = 1'b0;
        rdy = 1'b0;
        run(8);
        chk("full_count", 32'(bus.count), 32'd4);
        chk("full_no_req", 32'(bus.imem_req), 32'd0);
        chk("full_fetch_pc", 32'(bus.fetch_pc), 32'd4);
        rdy = 1'b1; obs.delete();
        run(8);
        chk("drain_order", 32'(obs.size() >= 5 ? {obs[0], obs[3], obs[4]} : 30'h3FFFFFFF),
            32'({10'd0, 10'd3, 10'd4}));

        // Redirect with count=3 and a response in flight.
        redir = 1'b1; rpc = 10'h200; run(1); redir = 1'b0;
        rdy = 1'b0; hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (mq.size() == 3 && m_pend) hit = 1'b1;
            else cycle();
        end
        chk("redir_setup", 32'(hit), 32'd1);
        redir = 1'b1; rpc = 10'h100; run(1); redir = 1'b0;
        chk("redir_count", 32'(bus.count), 32'd0);
        chk("redir_valid", 32'(bus.out_valid), 32'd0);
        chk("redir_fetch_pc", 32'(bus.fetch_pc), 32'h100);
        rdy = 1'b1; obs.delete();
        run(6);
        chk("redir_first_pc", 32'(obs.size() > 0 ? obs[0] : 10'h3FF), 32'h100);

        // Wrap-around at the top of the address space.
        redir = 1'b1; rpc = 10'd1022; run(1); redir = 1'b0;
        obs.delete();
        run(8);
        chk("wrap_seq", 32'(obs.size() >= 4 ? {obs[0], obs[1], obs[2]} : 30'h0),
            32'({10'd1022, 10'd1023, 10'd0}));
        chk("wrap_4th", 32'(obs.size() >= 4 ? obs[3] : 10'h3FF), 32'd1);

        // Pause mid-stream: queue drains, then fetch resumes in order.
        fen = 1'b0;
        run(5);
        chk("pause_drained", 32'(bus.count), 32'd0);
        chk("pause_no_req", 32'(bus.imem_req), 32'd0);
        fen = 1'b1;
        run(8);

        // Random traffic with occasional redirects and resets.
        for (int i = 0; i < 400; i++) begin
            fen   = ($urandom_range(0, 9) != 0);
            rdy   = ($urandom_range(0, 2) != 0);
            redir = ($urandom_range(0, 15) == 0);
            rpc   = PC_W'($urandom);
            rst   = ($urandom_range(0, 79) == 0);
            cycle();
        end
        rst = 1'b0; redir = 1'b0;
        run(3);

        // Reset mid-stream: everything cleared, stale response dropped.
        rst = 1'b1; run(1); rst = 1'b0;
        chk("rst2_count", 32'(bus.count), 32'd0);
        chk("rst2_fetch_pc", 32'(bus.fetch_pc), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst2_perf", 32'({bus.perf_fetched, bus.perf_flushed} | 32'(bus.perf_stall)), 32'd0);
`endif
        run(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Fetch stage directly upstream of the single-cycle controller.
- Owns the program counter and issues word addresses to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions with their PC in a small FIFO and presents them to the controller over a valid/ready handshake.
- The controller redirects fetch on taken branches, jumps and jr; a redirect flushes all buffered and in-flight instructions.

Parameters:
- PC_W, 10, width of PC and instruction-memory word address (0..1023).
- DEPTH, 4, FIFO entries (power of two, >=2).
- RESET_PC, 0, PC loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- fetch_en  in  1  1 = fetch allowed; 0 = pause issuing (FIFO still drains).
- imem_req  out  1  read request this cycle (combinational).
- imem_addr  out  PC_W  word address of request (= fetch_pc).
- imem_rdata  in  32  read data, valid the cycle after imem_req.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  controller accepts head.
- out_instr  out  32  head instruction.
- out_pc  out  PC_W  head PC.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  PC_W  new fetch PC.
- fetch_pc  out  PC_W  next PC to be issued.
- count  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- One clock (clk). Reset is synchronous, active-high, sampled on rising clk, and overrides every other input.
- Reset values: state=IDLE, fetch_pc=RESET_PC, count=0, out_valid=0, in-flight flag=0, FIFO pointers=0. out_instr and out_pc are don't-care while out_valid=0.
- States:
  - IDLE: entered only from reset; always goes to RUN next cycle if fetch_en=1, else PAUSE.
  - RUN: goes to PAUSE when fetch_en=0.
  - PAUSE: goes to RUN when fetch_en=1.
- imem_req = (state==RUN) && !redirect_valid && (count + inflight < DEPTH).
  - inflight = 1 if imem_req was high last cycle and no redirect occurred last cycle.
  - A pop in the same cycle is not credited.
- On imem_req: fetch_pc <= fetch_pc+1, modulo 2^PC_W (1023 -> 0). In-flight tag records the issued PC.
- Response: the cycle after a request, imem_rdata plus tagged PC are pushed at the FIFO tail, unless redirect_valid is high in that cycle; then they are discarded.
- Pop: out_valid && out_ready advances the head.
  - Push and pop in the same cycle leaves count unchanged.
  - The credit rule guarantees the FIFO never overflows. A push when count==DEPTH is an assertion failure.
- out_valid = (count != 0). The head is registered FIFO storage, with no combinational path from imem_rdata.
- Latency: an instruction requested in cycle N is visible at the head in N+2 at the earliest (response in N+1, written at the end of N+1).
- Redirect (redirect_valid=1 in cycle N):
  - A pop handshake in N is honoured.
  - All remaining entries are cleared: count=0 and out_valid=0 in N+1.
  - Any response arriving in N is dropped.
  - No request is issued in N.
  - fetch_pc=redirect_pc in N+1. The first request for redirect_pc occurs in N+1 if RUN and credit allow.
  - State is unchanged; a redirect in IDLE or PAUSE updates fetch_pc and flushes only.
- Back-to-back redirects: the last one wins, and each flushes.
- fetch_en falling with a request in flight: the response is still accepted.
- Reset mid-operation discards the FIFO and any in-flight response. The response arriving the cycle after reset is dropped.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetched[15:0] (pushes accepted into the FIFO), perf_flushed[15:0] (redirect events) and perf_stall[15:0] (cycles in RUN with imem_req=0 and no redirect).
  - All counters saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and logic are absent; core behaviour is identical.

Test Plan:
- Reset, fetch_en=1, out_ready=1, imem returns {22'h0, addr}:
  - imem_req first high in cycle 1 after reset.
  - out_valid first high in cycle 3 with out_pc=0, out_instr=0.
  - Thereafter one instruction per cycle, PCs 1,2,3,... in order.
- out_ready=0 held:
  - Exactly 4 requests are issued (PC 0..3); count saturates at 4 and imem_req stays 0.
  - Raise out_ready: entries are popped 0,1,2,3 and fetch resumes at PC 4.
- Redirect to 0x100 while count=3 and a request is in flight:
  - Next cycle count=0, out_valid=0, fetch_pc=0x100.
  - The dropped response never appears at the output.
  - The first output after the flush has out_pc=0x100.
- redirect_pc=1022, free-running:
  - Output PCs are 1022, 1023, 0, 1 (wrap-around, no gap).
- fetch_en=0 for 5 cycles mid-stream:
  - No imem_req; the FIFO drains to count=0.
  - fetch_en=1 resumes from the saved fetch_pc, with no duplicate or skipped PC.
- With FETCH_PERF_CNT_EN: run 10 pushes and 2 redirects.
  - perf_fetched=10, perf_flushed=2.
  - Assert reset: all counters read 0 the next cycle.
